bfxp_seq: RTL and testbench

- Multi-field bitfield gather sequencer.
- Accepts one command: a 32-bit source word, a 32-bit base word, and up to NFIELDS field descriptors (start, len, dest).
- Steps the descriptors one per cycle through a single rotate/mask/OR field datapath, feeding each result back as the next base.
- Returns the packed word over a valid/ready handshake. Sits between the instruction decode/issue stage and writeback, for multi-field extract-and-place sequences.

---
 rtl/bfxp_pkg.sv | 20 ++
 rtl/bfxp_if.sv | 49 ++++
 rtl/bfxp_field.sv | 34 +++
 rtl/bfxp_seq.sv | 110 +++++++++++
 tb/tb_bfxp_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bfxp_pkg.sv
// Shared types for the bitfield gather sequencer.
// Field descriptors, FSM states and widths.
package bfxp_pkg;

  localparam int XLEN    = 32;
  localparam int FIELD_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] start;
    logic [FIELD_W-1:0] len;
    logic [FIELD_W-1:0] dest;
  } desc_t;

endpackage

// File: rtl/bfxp_if.sv
// Command and result handshake bundle
// between issue, the sequencer and writeback.
interface bfxp_if #(
  parameter int NFIELDS = 4
) ();

  localparam int CW = $clog2(NFIELDS + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_src;
  logic [31:0]            in_base;
  logic [CW-1:0]          in_count;
  logic [5*NFIELDS-1:0]   in_start;
  logic [5*NFIELDS-1:0]   in_len;
  logic [5*NFIELDS-1:0]   in_dest;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;

  modport master (
    output in_valid,
    output in_src,
    output in_base,
    output in_count,
    output in_start,
    output in_len,
    output in_dest,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_src,
    input  in_base,
    input  in_count,
    input  in_start,
    input  in_len,
    input  in_dest,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/bfxp_field.sv
// One extract-and-place step: rotate the source
// so the field lands at dest, mask, OR into acc.
module bfxp_field
  import bfxp_pkg::*;
(
  input  logic [XLEN-1:0] src,
  input  logic [XLEN-1:0] acc,
  input  desc_t           desc,
  output logic [XLEN-1:0] result
);

  logic [FIELD_W-1:0] rot;
  logic [5:0]         rot_l;
  logic [XLEN-1:0]    rotated;
  logic [31:0]        lsh;
  logic [XLEN-1:0]    lmask;
  logic [XLEN-1:0]    rmask;

  // Rotate amount wraps mod 32 in the 5-bit subtract.
  assign rot   = desc.start - desc.dest;
  assign rot_l = 6'd32 - {1'b0, rot};

  // Left half of a shift of 32 yields zero, so rot=0 works.
  assign rotated = (src >> rot) | (src << rot_l);

  // Wraps past 31 when dest+len>32, killing the field.
  assign lsh = 32'd32 - 32'(desc.dest) - 32'(desc.len);

  assign lmask = {XLEN{1'b1}} >> lsh;
  assign rmask = {XLEN{1'b1}} << desc.dest;

  assign result = (rotated & lmask & rmask) | acc;

endmodule

// File: rtl/bfxp_seq.sv
// Multi-field gather sequencer: applies up to NFIELDS
// descriptors, one per cycle, then offers the result.
module bfxp_seq
  import bfxp_pkg::*;
#(
  parameter int NFIELDS = 4
) (
  input  logic  clock,
  input  logic  resetn,
  bfxp_if.slave bus
);

  localparam int CW = $clog2(NFIELDS + 1);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   cnt_clip;
  desc_t           desc_q [NFIELDS];
  desc_t           cur;
  logic [XLEN-1:0] step_res;
  logic            accept;
  logic            last;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = acc_q;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (idx_q == cnt_q - CW'(1));

  // Oversized counts run every available descriptor.
  always_comb begin
    cnt_clip = bus.in_count;
    if (bus.in_count > CW'(NFIELDS))
      cnt_clip = CW'(NFIELDS);
  end

  // Select the descriptor for the current step.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NFIELDS; i++)
      if (idx_q == CW'(i))
        cur = desc_q[i];
  end

  bfxp_field u_field (
    .src    (src_q),
    .acc    (acc_q),
    .desc   (cur),
    .result (step_res)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid)
          state_d = (cnt_clip != '0) ? RUN : DONE;
      end
      RUN: begin
        if (last)
          state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture and per-step accumulate.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      src_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < NFIELDS; i++)
        desc_q[i] <= '0;
    end else if (accept) begin
      src_q <= bus.in_src;
      acc_q <= bus.in_base;
      cnt_q <= cnt_clip;
      idx_q <= '0;
      for (int i = 0; i < NFIELDS; i++) begin
        desc_q[i].start <= bus.in_start[5*i +: 5];
        desc_q[i].len   <= bus.in_len[5*i +: 5];
        desc_q[i].dest  <= bus.in_dest[5*i +: 5];
      end
    end else if (state_q == RUN) begin
      acc_q <= step_res;
      idx_q <= idx_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_bfxp_seq.sv
// Directed bench for bfxp_seq with a result
// scoreboard and a bit-by-bit field model.
module tb_bfxp_seq;

  localparam int NF = 4;

  logic clock;
  logic resetn;

  bfxp_if #(.NFIELDS(NF)) bus ();

  bfxp_seq #(.NFIELDS(NF)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] q_exp [$];
  int          lat_exp;
  int          n_chk;
  int          n_pass;
  logic        hold_rdy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] fmodel(
    input logic [31:0] s,
    input logic [31:0] a,
    input logic [4:0]  st,
    input logic [4:0]  ln,
    input logic [4:0]  ds);
    logic [31:0] r;
    int e;
    r = a;
    e = int'(ds) + int'(ln);
    if (ln != 0 && e <= 32)
      for (int k = 0; k < int'(ln); k++)
        if (s[(int'(st) + k) % 32])
          r[int'(ds) + k] = 1'b1;
    return r;
  endfunction

  // Drive one command at the next edge, push expected.
  task automatic accept_cmd(
    input logic [31:0] src,
    input logic [31:0] base,
    input int          cnt,
    input logic [19:0] st,
    input logic [19:0] ln,
    input logic [19:0] ds);
    logic [31:0] acc;
    int n;
    n = (cnt > NF) ? NF : cnt;
    acc = base;
    for (int i = 0; i < n; i++)
      acc = fmodel(src, acc, st[5*i +: 5],
                   ln[5*i +: 5], ds[5*i +: 5]);
    q_exp.push_back(acc);
    lat_exp = n;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_src   = src;
    bus.in_base  = base;
    bus.in_count = 3'(cnt);
    bus.in_start = st;
    bus.in_len   = ln;
    bus.in_dest  = ds;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_src   = $urandom;
    bus.in_base  = $urandom;
    bus.in_start = 20'($urandom);
    bus.in_len   = 20'($urandom);
    bus.in_dest  = 20'($urandom);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for out_valid (bounded) and check latency.
  task automatic wait_out();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
  endtask

  // Take the result, compare against the scoreboard.
  task automatic take_out();
    logic [31:0] e;
    e = (q_exp.size() > 0) ? q_exp.pop_front() : 32'hx;
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_data", bus.out_data, e);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = hold_rdy;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_cmd(
    input logic [31:0] src,
    input logic [31:0] base,
    input int          cnt,
    input logic [19:0] st,
    input logic [19:0] ln,
    input logic [19:0] ds);
    accept_cmd(src, base, cnt, st, ln, ds);
    wait_out();
    take_out();
  endtask

  function automatic logic [19:0] pk(
    input int a, input int b,
    input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  initial begin
    logic [31:0] held;
    n_chk = 0;
    n_pass = 0;
    hold_rdy = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_src    = '0;
    bus.in_base   = '0;
    bus.in_count  = '0;
    bus.in_start  = '0;
    bus.in_len    = '0;
    bus.in_dest   = '0;
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clock) resetn = 1'b1;
    @(posedge clock); #1;

    // Single field.
    run_cmd(32'h12345678, 32'h0, 1,
            pk(8,0,0,0), pk(8,0,0,0), pk(0,0,0,0));
    chk("single_const", 32'h56, 32'h56 & 32'hff);

    // Nibble swap.
    run_cmd(32'h12345678, 32'h0, 2,
            pk(0,28,0,0), pk(4,4,0,0), pk(28,0,0,0));

    // count = 0.
    run_cmd(32'h0, 32'hDEADBEEF, 0,
            '0, '0, '0);

    // count clipped to NFIELDS.
    run_cmd(32'hCAFEF00D, 32'h0, 7,
            pk(0,8,16,24), pk(4,4,4,4),
            pk(0,8,16,24));

    // Overflowing field adds nothing.
    run_cmd(32'hFFFFFFFF, 32'hA5, 1,
            pk(0,0,0,0), pk(4,0,0,0), pk(30,0,0,0));

    // Field ending exactly at bit 31, and len=0.
    run_cmd(32'h0000000F, 32'h0, 2,
            pk(0,0,0,0), pk(4,0,0,0), pk(28,5,0,0));

    // Backpressure: result holds, new command ignored.
    accept_cmd(32'h12345678, 32'h0F000000, 1,
               pk(16,0,0,0), pk(12,0,0,0),
               pk(4,0,0,0));
    wait_out();
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_count = 3'd2;
      @(posedge clock); #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", bus.out_data, held);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    take_out();

    // Reset in the middle of a run.
    accept_cmd(32'hFFFFFFFF, 32'h0, 4,
               pk(0,4,8,12), pk(4,4,4,4),
               pk(0,4,8,12));
    @(posedge clock); #1;
    resetn = 1'b0;
    #2;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_data", bus.out_data, 32'd0);
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    q_exp.delete();
    @(negedge clock) resetn = 1'b1;
    @(posedge clock); #1;
    run_cmd(32'h12345678, 32'h0, 2,
            pk(0,28,0,0), pk(4,4,0,0), pk(28,0,0,0));

    // Random commands, out_ready held high throughout.
    hold_rdy = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 6; r++)
      run_cmd($urandom, $urandom,
              int'($urandom_range(0, 7)),
              20'($urandom), 20'($urandom),
              20'($urandom));
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
